// File: rtl/binary_map_pkg.sv
// Shared types and default constants for the binary map writer.
package binary_map_pkg;

  localparam int unsigned DIMEN_DEF        = 16;
  localparam int unsigned BINARY_WIDTH_DEF = 4;
  localparam int unsigned SCORE_WIDTH_DEF  = 16;
  localparam int unsigned SUM_W            = 32;
  localparam int unsigned INDEX_W          = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/binary_map_writer_if.sv
// Score stream in, row-buffer write port and row-sum reporting out.
interface binary_map_writer_if
  import binary_map_pkg::*;
#(
  parameter int unsigned dimen        = DIMEN_DEF,
  parameter int unsigned binary_width = BINARY_WIDTH_DEF,
  parameter int unsigned score_width  = SCORE_WIDTH_DEF
);

  logic                    start;
  logic [score_width-1:0]  threshold;
  logic [score_width-1:0]  score_in;
  logic                    score_valid;

  logic [binary_width:0]   binary_addr;
  logic                    binary_cen;
  logic                    binary_wen;
  logic                    binary_ren;
  logic [dimen-1:0]        binary_d;
  logic [SUM_W-1:0]        row_sum;
  logic [INDEX_W-1:0]      row_index;
  logic                    sum_valid;
  logic                    write_finish;

  modport master (
    output start, threshold, score_in, score_valid,
    input  binary_addr, binary_cen, binary_wen, binary_ren, binary_d,
    input  row_sum, row_index, sum_valid, write_finish
  );

  modport slave (
    input  start, threshold, score_in, score_valid,
    output binary_addr, binary_cen, binary_wen, binary_ren, binary_d,
    output row_sum, row_index, sum_valid, write_finish
  );

endinterface

// File: rtl/binary_map_writer_row_popcount.sv
// Combinational population count of one packed map row.
module row_popcount
  import binary_map_pkg::*;
#(
  parameter int unsigned dimen = DIMEN_DEF
) (
  input  logic [dimen-1:0] row,
  output logic [SUM_W-1:0] count
);

  // Sum of set bits across the row
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < dimen; i++) begin
      count = count + SUM_W'(row[i]);
    end
  end

endmodule

// File: rtl/binary_map_writer.sv
// Thresholds a row-major score stream into a dimen x dimen binary map and
// writes each packed row to an external buffer as one single-cycle pulse.
// Optional per-row popcount reporting: define BINARY_MAP_SUM_EN.
module binary_map_writer
  import binary_map_pkg::*;
#(
  parameter int unsigned dimen        = DIMEN_DEF,
  parameter int unsigned binary_width = BINARY_WIDTH_DEF,
  parameter int unsigned score_width  = SCORE_WIDTH_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  binary_map_writer_if.slave  bus
);

  localparam int unsigned CW = (dimen > 1) ? $clog2(dimen) : 1;
  localparam int unsigned AW = binary_width + 1;
  localparam logic [CW-1:0] LAST_ELEM = CW'(dimen - 1);
  localparam logic [AW-1:0] LAST_ROW  = AW'(dimen - 1);

  state_t                 state;
  logic [score_width-1:0] thr_q;
  logic [CW-1:0]          elem_cnt;
  logic [AW-1:0]          row_cnt;
  logic [dimen-1:0]       row_buf;
  logic [dimen-1:0]       row_next;
  logic                   hit;
  logic                   accept;
  logic                   row_done;

  // Element qualification and insertion of the new bit (first element at MSB)
  always_comb begin
    hit      = (bus.score_in >= thr_q);
    accept   = (state == COLLECT) && bus.score_valid && !bus.start;
    row_done = accept && (elem_cnt == LAST_ELEM);
    row_next = row_buf;
    row_next[LAST_ELEM - elem_cnt] = hit;
  end

  // Map FSM with registered buffer-port outputs; start wins in every state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state            <= IDLE;
      thr_q            <= '0;
      elem_cnt         <= '0;
      row_cnt          <= '0;
      row_buf          <= '0;
      bus.binary_addr  <= '0;
      bus.binary_cen   <= 1'b0;
      bus.binary_wen   <= 1'b1;
      bus.binary_ren   <= 1'b0;
      bus.binary_d     <= '0;
      bus.write_finish <= 1'b0;
    end else begin
      bus.binary_addr <= '0;
      bus.binary_cen  <= 1'b0;
      bus.binary_wen  <= 1'b1;
      bus.binary_d    <= '0;
      if (bus.start) begin
        state            <= COLLECT;
        thr_q            <= bus.threshold;
        elem_cnt         <= '0;
        row_cnt          <= '0;
        row_buf          <= '0;
        bus.binary_ren   <= 1'b1;
        bus.write_finish <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (row_done) begin
              // The output registers act as the write register: the pulse
              // appears on the cycle after the last element is accepted.
              bus.binary_cen  <= 1'b1;
              bus.binary_wen  <= 1'b0;
              bus.binary_addr <= row_cnt;
              bus.binary_d    <= row_next;
              row_buf         <= '0;
              elem_cnt        <= '0;
              if (row_cnt == LAST_ROW) begin
                row_cnt <= '0;
                state   <= DONE;
              end else begin
                row_cnt <= row_cnt + AW'(1);
              end
            end else if (accept) begin
              row_buf  <= row_next;
              elem_cnt <= elem_cnt + CW'(1);
            end
          end
          DONE: begin
            if (!bus.write_finish) begin
              bus.write_finish <= 1'b1;
              bus.binary_ren   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BINARY_MAP_SUM_EN
  logic [SUM_W-1:0] pop;

  row_popcount #(.dimen(dimen)) u_popcount (
    .row   (row_next),
    .count (pop)
  );

  // Row sum and 1-based index, aligned with the write pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.row_sum   <= '0;
      bus.row_index <= '0;
      bus.sum_valid <= 1'b0;
    end else begin
      bus.sum_valid <= row_done;
      if (row_done) begin
        bus.row_sum   <= pop;
        bus.row_index <= INDEX_W'(row_cnt) + INDEX_W'(1);
      end
    end
  end
`else
  assign bus.row_sum   = '0;
  assign bus.row_index = '0;
  assign bus.sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_binary_map_writer.sv
// Directed bench for binary_map_writer (sum checks follow BINARY_MAP_SUM_EN).
module tb_binary_map_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  binary_map_writer_if #(.dimen(16), .binary_width(4), .score_width(16)) bus ();

  binary_map_writer #(.dimen(16), .binary_width(4), .score_width(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Write-pulse recorder
  logic [4:0]  m_addr [64];
  logic [15:0] m_d    [64];
  logic [31:0] m_sum  [64];
  logic [15:0] m_idx  [64];
  logic        m_sv   [64];
  logic        m_wen  [64];
  logic        m_ren  [64];
  int          m_cyc  [64];
  int          m_n = 0;
  int          idle_bad = 0;
  int          sv_stray = 0;
  int          wf_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.binary_cen === 1'b1) begin
        if (m_n < 64) begin
          m_addr[m_n] = bus.binary_addr;
          m_d[m_n]    = bus.binary_d;
          m_sum[m_n]  = bus.row_sum;
          m_idx[m_n]  = bus.row_index;
          m_sv[m_n]   = bus.sum_valid;
          m_wen[m_n]  = bus.binary_wen;
          m_ren[m_n]  = bus.binary_ren;
          m_cyc[m_n]  = cyc;
        end
        m_n++;
      end else begin
        if (bus.binary_wen !== 1'b1 || bus.binary_addr !== 5'd0 || bus.binary_d !== 16'd0)
          idle_bad++;
        if (bus.sum_valid !== 1'b0) sv_stray++;
      end
      if (bus.write_finish === 1'b1 && wf_cyc < 0) wf_cyc = cyc;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    m_n = 0; idle_bad = 0; sv_stray = 0; wf_cyc = -1;
  endtask

  task automatic drive(input logic st, input logic [15:0] thr, input logic sv, input logic [15:0] sc);
    @(negedge clk);
    bus.start = st; bus.threshold = thr; bus.score_valid = sv; bus.score_in = sc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    total++; if (bus.binary_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.binary_addr); end
    total++; if (bus.binary_cen !== 1'b0) begin bad++; $display("FAIL rst_cen got=%b exp=0", bus.binary_cen); end
    total++; if (bus.binary_wen !== 1'b1) begin bad++; $display("FAIL rst_wen got=%b exp=1", bus.binary_wen); end
    total++; if (bus.binary_ren !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b exp=0", bus.binary_ren); end
    total++; if (bus.binary_d !== 16'd0) begin bad++; $display("FAIL rst_d got=%h exp=0", bus.binary_d); end
    total++; if (bus.row_sum !== 32'd0) begin bad++; $display("FAIL rst_sum got=%0d exp=0", bus.row_sum); end
    total++; if (bus.row_index !== 16'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", bus.row_index); end
    total++; if (bus.sum_valid !== 1'b0) begin bad++; $display("FAIL rst_sv got=%b exp=0", bus.sum_valid); end
    total++; if (bus.write_finish !== 1'b0) begin bad++; $display("FAIL rst_wf got=%b exp=0", bus.write_finish); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_row0();
    logic [15:0] pat;
    pat = 16'b0010010000000010;
    do_reset();
    clear_mon();
    drive(1'b1, 16'd5, 1'b0, 16'd0);
    for (int j = 0; j < 16; j++) drive(1'b0, 16'd0, 1'b1, pat[15-j] ? 16'd9 : 16'd0);
    idle(3);
    total++; if (m_n !== 1) begin bad++; $display("FAIL row0_count got=%0d exp=1", m_n); end
    total++; if (m_addr[0] !== 5'd0) begin bad++; $display("FAIL row0_addr got=%0d exp=0", m_addr[0]); end
    total++; if (m_d[0] !== pat) begin bad++; $display("FAIL row0_d got=%b exp=%b", m_d[0], pat); end
    total++; if (m_wen[0] !== 1'b0) begin bad++; $display("FAIL row0_wen got=%b exp=0", m_wen[0]); end
`ifdef BINARY_MAP_SUM_EN
    total++; if (m_sv[0] !== 1'b1) begin bad++; $display("FAIL row0_sv got=%b exp=1", m_sv[0]); end
    total++; if (m_sum[0] !== 32'd3) begin bad++; $display("FAIL row0_sum got=%0d exp=3", m_sum[0]); end
    total++; if (m_idx[0] !== 16'd1) begin bad++; $display("FAIL row0_idx got=%0d exp=1", m_idx[0]); end
`else
    total++; if (m_sv[0] !== 1'b0) begin bad++; $display("FAIL row0_sv got=%b exp=0", m_sv[0]); end
`endif
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL row0_idle got=%0d exp=0", idle_bad); end
  endtask

  task automatic test_threshold_equal();
    do_reset();
    clear_mon();
    drive(1'b1, 16'd7, 1'b0, 16'd0);
    for (int j = 0; j < 16; j++) begin
      case (j)
        0:  drive(1'b0, 16'd0, 1'b1, 16'd7);
        1:  drive(1'b0, 16'd0, 1'b1, 16'd6);
        2:  drive(1'b0, 16'd0, 1'b1, 16'd8);
        15: drive(1'b0, 16'd0, 1'b1, 16'hFFFF);
        default: drive(1'b0, 16'd0, 1'b1, 16'd0);
      endcase
    end
    idle(3);
    total++; if (m_n !== 1) begin bad++; $display("FAIL thr_count got=%0d exp=1", m_n); end
    total++; if (m_d[0] !== 16'hA001) begin bad++; $display("FAIL thr_d got=%h exp=a001", m_d[0]); end
`ifdef BINARY_MAP_SUM_EN
    total++; if (m_sum[0] !== 32'd3) begin bad++; $display("FAIL thr_sum got=%0d exp=3", m_sum[0]); end
`endif
  endtask

  task automatic test_full_map();
    logic [15:0] exp_row [16];
    int s;
    for (int r = 0; r < 16; r++) begin
      exp_row[r] = 16'd0;
      for (int j = 0; j < 16; j++) begin
        s = ((r * 7 + j * 3) % 11) * 20;
        exp_row[r][15-j] = (s >= 100);
      end
    end
    do_reset();
    clear_mon();
    drive(1'b1, 16'd100, 1'b0, 16'd0);
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 16; j++)
        drive(1'b0, 16'd0, 1'b1, 16'(((r * 7 + j * 3) % 11) * 20));
    // Scores after the map completes must be ignored
    for (int k = 0; k < 20; k++) drive(1'b0, 16'd0, 1'b1, 16'd200);
    idle(3);
    total++; if (m_n !== 16) begin bad++; $display("FAIL map_count got=%0d exp=16", m_n); end
    for (int r = 0; r < 16; r++) begin
      total++; if (m_addr[r] !== 5'(r)) begin bad++; $display("FAIL map_addr row=%0d got=%0d exp=%0d", r, m_addr[r], r); end
      total++; if (m_d[r] !== exp_row[r]) begin bad++; $display("FAIL map_d row=%0d got=%h exp=%h", r, m_d[r], exp_row[r]); end
      total++; if (m_wen[r] !== 1'b0 || m_ren[r] !== 1'b1) begin bad++; $display("FAIL map_wen_ren row=%0d got=%b%b exp=01", r, m_wen[r], m_ren[r]); end
`ifdef BINARY_MAP_SUM_EN
      total++; if (m_sv[r] !== 1'b1 || m_sum[r] !== 32'($countones(exp_row[r])) || m_idx[r] !== 16'(r + 1))
        begin bad++; $display("FAIL map_sum row=%0d got=%b/%0d/%0d exp=1/%0d/%0d", r, m_sv[r], m_sum[r], m_idx[r], $countones(exp_row[r]), r + 1); end
`else
      total++; if (m_sv[r] !== 1'b0 || m_sum[r] !== 32'd0) begin bad++; $display("FAIL map_nosum row=%0d got=%b/%0d exp=0/0", r, m_sv[r], m_sum[r]); end
`endif
      if (r > 0) begin
        total++; if (m_cyc[r] - m_cyc[r-1] !== 16) begin bad++; $display("FAIL map_spacing row=%0d got=%0d exp=16", r, m_cyc[r] - m_cyc[r-1]); end
      end
    end
    total++; if (wf_cyc !== m_cyc[15] + 1) begin bad++; $display("FAIL map_wf_cycle got=%0d exp=%0d", wf_cyc, m_cyc[15] + 1); end
    total++; if (bus.write_finish !== 1'b1) begin bad++; $display("FAIL map_wf_sticky got=%b exp=1", bus.write_finish); end
    total++; if (bus.binary_ren !== 1'b0) begin bad++; $display("FAIL map_ren_end got=%b exp=0", bus.binary_ren); end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL map_idle got=%0d exp=0", idle_bad); end
    total++; if (sv_stray !== 0) begin bad++; $display("FAIL map_sv_stray got=%0d exp=0", sv_stray); end
  endtask

  task automatic test_restart();
    logic [15:0] pat2;
    pat2 = 16'hC35A;
    do_reset();
    clear_mon();
    drive(1'b1, 16'd5, 1'b0, 16'd0);
    for (int k = 0; k < 20; k++) drive(1'b0, 16'd0, 1'b1, 16'd9);
    // Restart coincides with a valid score, which must be dropped
    drive(1'b1, 16'd50, 1'b1, 16'd9);
    for (int j = 0; j < 16; j++) drive(1'b0, 16'd0, 1'b1, pat2[15-j] ? 16'd60 : 16'd9);
    idle(3);
    total++; if (m_n !== 2) begin bad++; $display("FAIL rs_count got=%0d exp=2", m_n); end
    total++; if (m_addr[0] !== 5'd0 || m_d[0] !== 16'hFFFF) begin bad++; $display("FAIL rs_first got=%0d/%h exp=0/ffff", m_addr[0], m_d[0]); end
    total++; if (m_addr[1] !== 5'd0) begin bad++; $display("FAIL rs_addr got=%0d exp=0", m_addr[1]); end
    total++; if (m_d[1] !== pat2) begin bad++; $display("FAIL rs_d got=%h exp=%h", m_d[1], pat2); end
`ifdef BINARY_MAP_SUM_EN
    total++; if (m_sum[1] !== 32'd8 || m_idx[1] !== 16'd1) begin bad++; $display("FAIL rs_sum got=%0d/%0d exp=8/1", m_sum[1], m_idx[1]); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_mon();
    drive(1'b1, 16'd5, 1'b0, 16'd0);
    for (int k = 0; k < 64; k++) drive(1'b0, 16'd0, 1'b1, 16'd9);
    @(posedge clk);
    #2;
    total++; if (bus.binary_cen !== 1'b1 || bus.binary_addr !== 5'd3) begin bad++; $display("FAIL mid_pulse got=%b/%0d exp=1/3", bus.binary_cen, bus.binary_addr); end
    total++; if (m_n !== 3) begin bad++; $display("FAIL mid_prior got=%0d exp=3", m_n); end
    rst = 1'b1;
    #1;
    total++; if (bus.binary_cen !== 1'b0 || bus.binary_wen !== 1'b1) begin bad++; $display("FAIL mid_cen_wen got=%b%b exp=01", bus.binary_cen, bus.binary_wen); end
    total++; if (bus.binary_addr !== 5'd0 || bus.binary_d !== 16'd0) begin bad++; $display("FAIL mid_addr_d got=%0d/%h exp=0/0", bus.binary_addr, bus.binary_d); end
    total++; if (bus.binary_ren !== 1'b0 || bus.sum_valid !== 1'b0 || bus.row_sum !== 32'd0 || bus.row_index !== 16'd0)
      begin bad++; $display("FAIL mid_misc got=%b/%b/%0d/%0d exp=0/0/0/0", bus.binary_ren, bus.sum_valid, bus.row_sum, bus.row_index); end
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 40; k++) drive(1'b0, 16'd0, 1'b1, 16'd9);
    idle(3);
    total++; if (m_n !== 0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", m_n); end
    total++; if (bus.write_finish !== 1'b0) begin bad++; $display("FAIL mid_wf got=%b exp=0", bus.write_finish); end
  endtask

  initial begin
    bus.start = 1'b0; bus.threshold = '0; bus.score_valid = 1'b0; bus.score_in = '0;
    test_reset();
    test_row0();
    test_threshold_equal();
    test_full_map();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_map_writer.md
BINARY_MAP_WRITER -- requirements
Module: binary_map_writer

Interface
REQ-001 SHALL have parameter dimen, default 16: scores per row and rows per map.
REQ-002 SHALL have parameter binary_width, default 4: map address width is binary_width+1 bits.
REQ-003 SHALL have parameter score_width, default 16: score and threshold width (unsigned).
REQ-004 SHALL have port CLK, input, 1 bit: the only clock; all logic updates on the rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a new map.
REQ-007 SHALL have port threshold, input, score_width bits: the compare threshold, sampled on start.
REQ-008 SHALL have port score_in, input, score_width bits: the next score in row-major order.
REQ-009 SHALL have port score_valid, input, 1 bit: score_in is valid this cycle; no backpressure exists.
REQ-010 SHALL have port binary_addr, output, binary_width+1 bits: the map row address.
REQ-011 SHALL have port binary_cen, output, 1 bit: buffer chip enable, active-high.
REQ-012 SHALL have port binary_wen, output, 1 bit: buffer write enable, active-low (0 = write, 1 = read/idle).
REQ-013 SHALL have port binary_ren, output, 1 bit: buffer retention enable; 1 from start until write_finish.
REQ-014 SHALL have port binary_d, output, dimen bits: the packed row written to the buffer.
REQ-015 SHALL have port row_sum, output, 32 bits: the popcount of the written row, zero-extended.
REQ-016 SHALL have port row_index, output, 16 bits: the 1-based row number paired with row_sum.
REQ-017 SHALL have port sum_valid, output, 1 bit: row_sum and row_index are valid this cycle.
REQ-018 SHALL have port write_finish, output, 1 bit: all dimen rows are written; sticky until the next start or RESET.

Function
REQ-019 SHALL use FSM states IDLE, COLLECT, DONE: IDLE->COLLECT on start; COLLECT->DONE on the cycle the write pulse for row dimen-1 is issued; DONE->COLLECT on start.
REQ-020 SHALL compute each map bit as (score_in >= threshold), unsigned, on every cycle where score_valid=1 in COLLECT.
REQ-021 SHALL place element j of a row at bit dimen-1-j of binary_d (first element at the MSB).
REQ-022 SHALL, when the dimen-th element of a row is accepted, copy the packed row into a write register; on the next cycle drive binary_cen=1, binary_wen=0, binary_addr=row, binary_d=that row for exactly one cycle.
REQ-023 SHALL keep accepting scores during the write cycle with no lost elements; back-to-back rows at one score per cycle are legal.
REQ-024 SHALL drive row_sum (the popcount of the row) and row_index=row+1 with sum_valid=1 in the same cycle as the write pulse.
REQ-025 SHALL drive binary_cen=0, binary_wen=1, binary_addr=0 and binary_d=0 in all non-write cycles.
REQ-026 SHALL ignore score_valid in IDLE and DONE.
REQ-027 SHALL, on start in COLLECT (restart), clear the element and row counters and the partial row, resample threshold and cancel any pending write in that cycle.
REQ-028 SHALL, when start and score_valid coincide, take start and discard the score.
REQ-029 SHALL make write_finish rise on the cycle after the last write pulse.

Reset
REQ-030 SHALL, on RESET=1, immediately set state=IDLE, clear all counters and registers, and drive binary_addr=0, binary_cen=0, binary_wen=1, binary_ren=0, binary_d=0, row_sum=0, row_index=0, sum_valid=0, write_finish=0.
REQ-031 SHALL, on RESET asserted mid-map, abort the map with no further write pulses.

Configuration
REQ-032 SHALL, with macro BINARY_MAP_SUM_EN defined, provide the row_sum, row_index and sum_valid behaviour above.
REQ-033 SHALL, with BINARY_MAP_SUM_EN undefined, omit the popcount logic and tie row_sum, row_index and sum_valid to 0; ports remain present.

Structure
REQ-034 SHALL place the FSM state typedef, the default dimen/binary_width/score_width constants and the sum width (32) in a shared package, binary_map_pkg.
REQ-035 SHALL implement the popcount as one combinational sub-module, row_popcount (parameter dimen).

Verification
REQ-036 SHALL cover: threshold=5, row 0 scores = 9 where the bit is 1 in 16'b0010010000000010, else 0 -> write addr 0, D=16'b0010010000000010, row_sum=3, row_index=1.
REQ-037 SHALL cover: 256 consecutive valid scores (full map) -> 16 write pulses, addr 0..15, each exactly 16 cycles apart; write_finish=1 one cycle after the last pulse.
REQ-038 SHALL cover: score equal to threshold (7 vs 7) -> bit 1; score 6 -> bit 0.
REQ-039 SHALL cover: start after 20 scores -> no write of a partial row; the next 16 scores are written to addr 0.
REQ-040 SHALL cover: RESET asserted during the write cycle of row 3 -> outputs go to reset values asynchronously; no further writes.
REQ-041 SHALL cover: build with BINARY_MAP_SUM_EN undefined, full map -> writes are identical to REQ-037; sum_valid stays 0 throughout.
